// File: rtl/core_msg_arbiter_pkg.sv
// Shared definitions for the core message arbiter: message field layout,
// flag validity check and the round-robin search used by rr arbiters.
package core_msg_arbiter_pkg;

  localparam int FLAG_LSB = 0;
  localparam int LEN_LSB  = 16;
  localparam int LEN_W    = 16;
  localparam int RR_MAX   = 32;

  // True when exactly one bit of the (zero-extended) flag field is set.
  function automatic logic onehot_ok(input logic [63:0] flags);
    return (flags != 64'd0) && ((flags & (flags - 64'd1)) == 64'd0);
  endfunction

  // First set bit of req searching ptr+1, ptr+2, ... modulo n; -1 if none.
  function automatic int rr_search(input logic [RR_MAX-1:0] req, input int ptr, input int n);
    int idx;
    int c;
    idx = -1;
    for (int k = 1; k <= RR_MAX; k++) begin
      c = ptr + k;
      if (c >= n) c = c - n;
      if (k <= n && idx < 0 && req[c]) idx = c;
    end
    return idx;
  endfunction

endpackage

// File: rtl/core_msg_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request after i_ptr.
// Kept generic so other schedulers can reuse it.
module core_msg_arbiter_rr_arbiter
  import core_msg_arbiter_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_grant_valid
);

  logic [RR_MAX-1:0] w_req_ext;
  int                w_idx;

  always_comb begin
    w_req_ext        = '0;
    w_req_ext[N-1:0] = i_req;
    w_idx            = rr_search(w_req_ext, int'(i_ptr), N);
    o_grant_valid    = (w_idx >= 0);
    o_grant_idx      = '0;
    o_grant          = '0;
    if (w_idx >= 0) begin
      o_grant_idx    = IW'(w_idx);
      o_grant[w_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/core_msg_arbiter.sv
// Shares one message channel among CORE_COUNT cores via one-entry buffers and
// a round-robin grant into a registered output. Optional counters: CORE_MSG_ARB_STATS_EN.
module core_msg_arbiter
  import core_msg_arbiter_pkg::*;
#(
  parameter int CORE_COUNT    = 8,
  parameter int SLOT_COUNT    = 16,
  parameter int MSG_WIDTH     = 64,
  parameter int CORE_NO_WIDTH = $clog2(CORE_COUNT)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0]  s_msg_data,
  input  logic [CORE_COUNT-1:0]            s_msg_valid,
  output logic [CORE_COUNT-1:0]            s_msg_ready,
  output logic [MSG_WIDTH-1:0]             m_msg_data,
  output logic [CORE_NO_WIDTH-1:0]         m_msg_core_no,
  output logic                             m_msg_valid,
  input  logic                             m_msg_ready,
  input  logic [CORE_COUNT-1:0]            core_en,
  input  logic                             core_en_valid,
  output logic                             err_bad_flag,
  output logic [CORE_NO_WIDTH-1:0]         err_core
`ifdef CORE_MSG_ARB_STATS_EN
  ,
  input  logic [CORE_NO_WIDTH-1:0]         stat_rd_addr,
  output logic [31:0]                      stat_rd_data
`endif
);

  // Handshake: a transfer happens on a cycle where valid and ready are both high;
  // valid must not depend on ready, and output valid/data hold until ready.
  logic [CORE_COUNT-1:0]    r_buf_full, r_core_en;
  logic [MSG_WIDTH-1:0]     r_buf_data [CORE_COUNT];
  logic [CORE_NO_WIDTH-1:0] r_rr_ptr, r_m_core_no, r_err_core;
  logic [MSG_WIDTH-1:0]     r_m_data;
  logic                     r_m_valid, r_err_bad;

  logic [CORE_COUNT-1:0]    w_req, w_grant_oh, w_grant, w_accept;
  logic [CORE_NO_WIDTH-1:0] w_grant_idx;
  logic [MSG_WIDTH-1:0]     w_win_data;
  logic                     w_grant_found, w_out_free, w_do_grant, w_good, w_load_good, w_drop;

  assign w_out_free = !r_m_valid | m_msg_ready;
  assign w_req      = r_buf_full & r_core_en;

  core_msg_arbiter_rr_arbiter #(.N(CORE_COUNT), .IW(CORE_NO_WIDTH)) u_rr (
    .i_req         (w_req),
    .i_ptr         (r_rr_ptr),
    .o_grant       (w_grant_oh),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_found)
  );

  assign w_do_grant  = w_out_free & w_grant_found;
  assign w_grant     = w_do_grant ? w_grant_oh : '0;
  assign w_win_data  = r_buf_data[w_grant_idx];
  assign w_good      = onehot_ok(64'(w_win_data[FLAG_LSB +: SLOT_COUNT]));
  assign w_load_good = w_do_grant & w_good;
  assign w_drop      = w_do_grant & !w_good;

  // Granting frees the buffer this cycle, so a core can refill back-to-back.
  assign s_msg_ready = ~r_buf_full | w_grant;
  assign w_accept    = s_msg_valid & s_msg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_full <= '0;
      for (int i = 0; i < CORE_COUNT; i++) r_buf_data[i] <= '0;
    end else begin
      for (int i = 0; i < CORE_COUNT; i++) begin
        if (w_accept[i]) begin
          r_buf_full[i] <= 1'b1;
          r_buf_data[i] <= s_msg_data[i*MSG_WIDTH +: MSG_WIDTH];
        end else if (w_grant[i]) begin
          r_buf_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= CORE_NO_WIDTH'(CORE_COUNT - 1);
      r_core_en   <= '1;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_core_no <= '0;
      r_err_bad   <= 1'b0;
      r_err_core  <= '0;
    end else begin
      if (core_en_valid) r_core_en <= core_en;
      if (w_do_grant) r_rr_ptr <= w_grant_idx;
      if (w_out_free) begin
        r_m_valid <= w_load_good;
        if (w_load_good) begin
          r_m_data    <= w_win_data;
          r_m_core_no <= w_grant_idx;
        end
      end
      r_err_bad <= w_drop;
      if (w_drop) r_err_core <= w_grant_idx;
    end
  end

  assign m_msg_valid   = r_m_valid;
  assign m_msg_data    = r_m_data;
  assign m_msg_core_no = r_m_core_no;
  assign err_bad_flag  = r_err_bad;
  assign err_core      = r_err_core;

`ifdef CORE_MSG_ARB_STATS_EN
  localparam bit POW2 = (CORE_COUNT == (1 << CORE_NO_WIDTH));
  logic [31:0] r_cnt [CORE_COUNT];
  logic [15:0] r_drop;
  logic [31:0] r_stat_rd;
  logic [31:0] w_cnt_rd;

  assign w_cnt_rd = (int'(stat_rd_addr) < CORE_COUNT) ? r_cnt[stat_rd_addr] : 32'd0;

  // With a power-of-two core count the all-ones address shares its upper half with the drop count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CORE_COUNT; i++) r_cnt[i] <= '0;
      r_drop    <= '0;
      r_stat_rd <= '0;
    end else begin
      if (w_load_good) r_cnt[w_grant_idx] <= r_cnt[w_grant_idx] + 32'd1;
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      r_stat_rd <= (POW2 && (&stat_rd_addr)) ? {r_drop, w_cnt_rd[15:0]} : w_cnt_rd;
    end
  end

  assign stat_rd_data = r_stat_rd;
`endif

endmodule
